// File: rtl/mem_wr_pkg.sv
// Shared constants and types for the write-side burst sequencer of the
// dual-clock 64x8 byte memory.
package mem_wr_pkg;

   localparam int unsigned MEM_WR_DW = 8;
   localparam int unsigned MEM_WR_AW = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DONE  = 2'd2
   } wr_state_e;

   // Burst length, 0..DEPTH inclusive, hence one bit wider than an address.
   typedef logic [MEM_WR_AW:0] wr_len_t;

endpackage

// File: rtl/mem_burst_writer_addr_gen.sv
// burst_addr_gen: loadable wrapping write pointer plus the remaining-bytes
// and bytes-written counters of the current burst.
module burst_addr_gen
   import mem_wr_pkg::*;
#(
   parameter int unsigned AW = MEM_WR_AW
)(
   input  logic          clk_wr,
   input  logic          rst,
   input  logic          i_load,
   input  logic [AW-1:0] i_addr,
   input  logic [AW:0]   i_len,
   input  logic          i_step,
   output logic [AW-1:0] o_ptr,
   output logic [AW:0]   o_count,
   output logic          o_last
);

   localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
   localparam logic [AW:0]   LEN_ONE = (AW+1)'(1'b1);

   logic [AW-1:0] r_ptr;
   logic [AW:0]   r_rem;
   logic [AW:0]   r_count;

   // Load on command accept, advance once per accepted byte; the pointer wraps naturally at DEPTH.
   always_ff @(posedge clk_wr) begin
      if (rst) begin
         r_ptr   <= '0;
         r_rem   <= '0;
         r_count <= '0;
      end else if (i_load) begin
         r_ptr   <= i_addr;
         r_rem   <= i_len;
         r_count <= '0;
      end else if (i_step) begin
         r_ptr   <= r_ptr + PTR_ONE;
         r_rem   <= r_rem - LEN_ONE;
         r_count <= r_count + LEN_ONE;
      end else begin
         r_ptr   <= r_ptr;
         r_rem   <= r_rem;
         r_count <= r_count;
      end
   end

   assign o_ptr   = r_ptr;
   assign o_count = r_count;
   assign o_last  = (r_rem == LEN_ONE);

endmodule

// File: rtl/mem_burst_writer.sv
// mem_burst_writer: accepts a (start address, length) burst command, then
// streams bytes into the memory write port, one registered write per
// accepted byte, with address wrap-around. Write-select is low whenever idle.
// Optional feature macro: MEM_WR_CHECKSUM_EN adds the csum output, the
// running XOR of the bytes accepted in the current burst.
module mem_burst_writer
   import mem_wr_pkg::*;
#(
   parameter int unsigned DW = MEM_WR_DW,
   parameter int unsigned AW = MEM_WR_AW
)(
   input  logic          clk_wr,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW:0]   cmd_len,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          mem_wr_rd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   wr_count
`ifdef MEM_WR_CHECKSUM_EN
   ,
   output logic [DW-1:0] csum
`endif
);

   wr_state_e     r_state;
   wr_state_e     w_next_state;

   logic          w_cmd_ready;
   logic          w_in_ready;
   logic          w_busy;
   logic          w_done;
   logic          w_cmd_accept;
   logic          w_byte_accept;
   logic          w_last;
   logic [AW-1:0] w_ptr;
   logic [AW:0]   w_count;

   logic          r_mem_wr_rd;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_data;

   assign w_cmd_accept  = cmd_valid & w_cmd_ready;
   assign w_byte_accept = in_valid & w_in_ready;

   burst_addr_gen #(
      .AW (AW)
   ) u_addr_gen (
      .clk_wr  (clk_wr),
      .rst     (rst),
      .i_load  (w_cmd_accept),
      .i_addr  (cmd_addr),
      .i_len   (cmd_len),
      .i_step  (w_byte_accept),
      .o_ptr   (w_ptr),
      .o_count (w_count),
      .o_last  (w_last)
   );

   // State register.
   always_ff @(posedge clk_wr) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: zero-length commands skip straight to DONE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_cmd_accept) begin
               if (cmd_len == {(AW+1){1'b0}}) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = ST_BURST;
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (w_byte_accept && w_last) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_BURST;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State-decoded handshake and status outputs, all held low while reset is asserted.
   always_comb begin
      w_cmd_ready = 1'b0;
      w_in_ready  = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               w_cmd_ready = 1'b1;
            end
            ST_BURST: begin
               w_in_ready = 1'b1;
               w_busy     = 1'b1;
            end
            ST_DONE: begin
               w_busy = 1'b1;
               w_done = 1'b1;
            end
            default: begin
               w_cmd_ready = 1'b0;
               w_in_ready  = 1'b0;
               w_busy      = 1'b0;
               w_done      = 1'b0;
            end
         endcase
      end else begin
         w_cmd_ready = 1'b0;
         w_in_ready  = 1'b0;
         w_busy      = 1'b0;
         w_done      = 1'b0;
      end
   end

   // Registered write port: one-cycle strobe per accepted byte; address/data hold through gaps.
   always_ff @(posedge clk_wr) begin
      if (rst) begin
         r_mem_wr_rd <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_data  <= '0;
      end else if (w_byte_accept) begin
         r_mem_wr_rd <= 1'b1;
         r_mem_addr  <= w_ptr;
         r_mem_data  <= in_data;
      end else begin
         r_mem_wr_rd <= 1'b0;
         r_mem_addr  <= r_mem_addr;
         r_mem_data  <= r_mem_data;
      end
   end

   assign cmd_ready = w_cmd_ready;
   assign in_ready  = w_in_ready;
   assign busy      = w_busy;
   assign done      = w_done;
   assign mem_wr_rd = r_mem_wr_rd;
   assign mem_addr  = r_mem_addr;
   assign mem_data  = r_mem_data;
   assign wr_count  = w_count;

`ifdef MEM_WR_CHECKSUM_EN
   logic [DW-1:0] r_csum;

   function automatic logic [DW-1:0] csum_step(input logic [DW-1:0] acc,
                                               input logic [DW-1:0] b);
      return acc ^ b;
   endfunction

   // Running XOR of accepted bytes; cleared on each new command so it stays valid until the next one.
   always_ff @(posedge clk_wr) begin
      if (rst) begin
         r_csum <= '0;
      end else if (w_cmd_accept) begin
         r_csum <= '0;
      end else if (w_byte_accept) begin
         r_csum <= csum_step(r_csum, in_data);
      end else begin
         r_csum <= r_csum;
      end
   end

   assign csum = r_csum;
`endif

endmodule

// File: doc/mem_burst_writer.md
Name: mem_burst_writer

Overview:
Upstream write-side sequencer for the dual-clock 64x8 byte memory. It accepts a burst command (start address, length), then accepts a byte stream over a valid/ready handshake. It drives the memory's write-select, address and data inputs, one byte per clk_wr cycle, with address wrap-around. It runs entirely in the clk_wr domain and holds the write-select low whenever idle, which frees the memory for reads.

Parameters:
DW, 8, data width in bits
AW, 6, address width; DEPTH = 2**AW (local, 64)

Ports:
clk_wr  input  1  write-domain clock, rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  burst command valid
cmd_ready  output  1  writer can accept a command (high only in IDLE)
cmd_addr  input  AW  burst start address
cmd_len  input  AW+1  bytes in burst, 0..DEPTH
in_valid  input  1  stream byte valid
in_ready  output  1  writer accepts a byte (high only in BURST)
in_data  input  DW  stream byte
mem_wr_rd  output  1  1 = write strobe to memory, 0 = idle/read allowed
mem_addr  output  AW  memory address
mem_data  output  DW  memory write data
busy  output  1  high in BURST or DONE
done  output  1  one-cycle pulse at burst completion
wr_count  output  AW+1  bytes written in current/last burst

Behaviour:
- Reset (rst=1 at clk_wr edge): state=IDLE. All outputs and internal counters are 0. cmd_ready=0 during reset cycles and 1 from the first cycle after.
- Reset mid-burst: the burst is abandoned. No further mem writes occur. The write already presented completes and is not retracted.
- FSM states: IDLE, BURST, DONE.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch ptr=cmd_addr, remaining=cmd_len, and clear wr_count. Go to DONE if cmd_len==0, else go to BURST.
  - BURST: in_ready=1 combinationally from state. Each cycle with in_valid&&in_ready accepts a byte, ptr<=ptr+1 (mod DEPTH, so 63 wraps to 0), remaining--, wr_count++. Accepting the byte with remaining==1 moves the FSM to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. Commands are not accepted in DONE.
- Write port is registered:
  - A byte accepted at edge N appears as mem_wr_rd=1, mem_addr=ptr, mem_data=in_data in cycle N+1, for one cycle only.
  - Back-to-back accepts give one write per cycle.
  - In gaps (in_valid=0), mem_wr_rd=0 and mem_addr/mem_data hold their last values.
- done coincides with the cycle presenting the final write.
- cmd_len>DEPTH is illegal. Behaviour is unspecified; a bench assertion flags it.
- in_valid outside BURST is ignored; no write results.
- cmd_valid outside IDLE is ignored and stalls via cmd_ready=0.

Optional Feature:
MEM_WR_CHECKSUM_EN.
- Defined: adds output csum [DW-1:0], the running XOR of all bytes accepted in the current burst. It is cleared on command accept and on reset, and is stable and valid while done=1 and afterwards until the next command.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
Package mem_wr_pkg holds:
- DW/AW default constants
- the state enum typedef (IDLE, BURST, DONE)
- the length type typedef (logic [AW:0])

One sub-module, burst_addr_gen, is natural. It contains the loadable wrapping ptr, the remaining counter and the wr_count counter, with load/step inputs and a last flag. The FSM and the write-port registers stay in mem_burst_writer.

Test Plan:
- Reset check: rst=1 for 2 cycles with random inputs -> all outputs 0. cmd_ready=1 in the first post-reset cycle. No mem_wr_rd pulses.
- Basic burst: cmd addr=5 len=3, bytes A1,A2,A3 back-to-back -> writes (5,A1),(6,A2),(7,A3) on 3 consecutive cycles. done is high with the (7,A3) write. wr_count=3.
- Wrap-around: addr=62 len=4, bytes 11,22,33,44 -> addresses 62,63,0,1 in order. done pulses once.
- Throttled stream: addr=0 len=3 with in_valid pattern 1,0,0,1,0,1 -> exactly 3 writes to 0,1,2. mem_wr_rd=0 in gap cycles. done one cycle wide.
- Zero length and mid-burst reset:
  - len=0 -> no writes, done pulses the cycle after accept, wr_count=0.
  - addr=10 len=5 with rst asserted after 2 accepts -> only writes to 10,11. FSM returns to IDLE with outputs 0.
- With MEM_WR_CHECKSUM_EN: bytes 0x0F,0xF0,0x33 -> csum=0xCC while done=1. A new command clears csum to 0.
